// File: rtl/seq_decoder.sv
// One-hot line decoder with three behaviours: static hold, single-cycle pulse,
// and a timed scan that walks every line with a programmable dwell.
module seq_decoder #(
   parameter int N       = 3,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_n,
   input  logic [1:0]         mode,
   input  logic [N-1:0]       addr,
   input  logic               addr_valid,
   output logic               addr_ready,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2**N-1:0]    d,
   output logic               busy,
   output logic               wrap
);

   localparam int L = 2**N;
   localparam logic [1:0] MODE_STATIC = 2'b00;
   localparam logic [1:0] MODE_PULSE  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;
   localparam logic [N-1:0]       IDX_ONE = 1;
   localparam logic [DWELL_W-1:0] CNT_ONE = 1;
   localparam logic [L-1:0]       LINE0   = 1;

   typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;

   state_t             state, state_nxt;
   logic [N-1:0]       index, index_nxt;
   logic [DWELL_W-1:0] counter, counter_nxt;
   logic [DWELL_W-1:0] dwell_reg, dwell_nxt;
   logic [L-1:0]       d_nxt;
   logic               busy_nxt, wrap_nxt;
   logic               accept;

   // rst_n is folded in because state already reads IDLE while reset is held
   assign addr_ready = rst_n && !en_n && (state != SCAN) && (mode != MODE_RSVD);
   assign accept     = addr_valid && addr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         index     <= '0;
         counter   <= '0;
         dwell_reg <= '0;
         d         <= '0;
         busy      <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         state     <= state_nxt;
         index     <= index_nxt;
         counter   <= counter_nxt;
         dwell_reg <= dwell_nxt;
         d         <= d_nxt;
         busy      <= busy_nxt;
         wrap      <= wrap_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      index_nxt   = index;
      counter_nxt = counter;
      dwell_nxt   = dwell_reg;
      d_nxt       = d;
      busy_nxt    = 1'b0;
      wrap_nxt    = 1'b0;

      if (en_n) begin
         state_nxt   = IDLE;
         counter_nxt = '0;
         d_nxt       = '0;
      end else if (state == SCAN) begin
         if (mode != MODE_SCAN) begin
            state_nxt = IDLE;
            d_nxt     = '0;
         end else if (counter == '0) begin
            index_nxt   = index + IDX_ONE;
            counter_nxt = dwell_reg;
            d_nxt       = LINE0 << (index + IDX_ONE);
            wrap_nxt    = &index;
            busy_nxt    = 1'b1;
         end else begin
            counter_nxt = counter - CNT_ONE;
            busy_nxt    = 1'b1;
         end
      end else if (accept) begin
         d_nxt = LINE0 << addr;
         case (mode)
            MODE_STATIC: state_nxt = HOLD;
            MODE_PULSE:  state_nxt = IDLE;
            MODE_SCAN: begin
               state_nxt   = SCAN;
               index_nxt   = addr;
               counter_nxt = dwell;
               dwell_nxt   = dwell;
               busy_nxt    = 1'b1;
            end
            default:     state_nxt = state;
         endcase
      end else if (state == IDLE) begin
         // IDLE only shows a line for the single cycle after a pulse accept
         d_nxt = '0;
      end
   end

endmodule

// File: tb/tb_seq_decoder.sv
// Directed-vector bench for seq_decoder (N=3, DWELL_W=4).
module tb_seq_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en_n;
   logic [1:0] mode;
   logic [2:0] addr;
   logic       addr_valid;
   logic       addr_ready;
   logic [3:0] dwell;
   logic [7:0] d;
   logic       busy;
   logic       wrap;

   int vectors = 0;
   int errors  = 0;

   seq_decoder #(.N(3), .DWELL_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_n       (en_n),
      .mode       (mode),
      .addr       (addr),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .dwell      (dwell),
      .d          (d),
      .busy       (busy),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [2:0] a,
                                input logic v, input logic [3:0] dw);
      en_n       = e;
      mode       = m;
      addr       = a;
      addr_valid = v;
      dwell      = dw;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkState(input string tag, input logic [7:0] ed, input logic eb,
                             input logic ew, input logic er);
      checkOutput({tag, ".d"}, 32'(d), 32'(ed));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(eb));
      checkOutput({tag, ".wrap"}, 32'(wrap), 32'(ew));
      checkOutput({tag, ".ready"}, 32'(addr_ready), 32'(er));
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'b00, 3'd6, 1'b1, 4'd0);
      checkState("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;

      // STATIC: line 6 held, then replaced by line 1 with no zero gap
      checkOutput("static.ready", 32'(addr_ready), 32'd1);
      tick();
      checkState("static.a6", 8'h40, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 3'd6, 1'b0, 4'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("static.hold", 32'(d), 32'h40);
      end
      applyStimulus(1'b0, 2'b00, 3'd1, 1'b1, 4'd0);
      tick();
      checkOutput("static.a1", 32'(d), 32'h02);

      // PULSE: one cycle of line 5, then zero
      applyStimulus(1'b0, 2'b01, 3'd5, 1'b1, 4'd0);
      checkOutput("pulse.ready0", 32'(addr_ready), 32'd1);
      tick();
      checkState("pulse.on", 8'h20, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b01, 3'd5, 1'b0, 4'd0);
      tick();
      checkState("pulse.off", 8'h00, 1'b0, 1'b0, 1'b1);

      // SCAN from 6 with dwell 1, through the wrap
      applyStimulus(1'b0, 2'b10, 3'd6, 1'b1, 4'd1);
      tick();
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b0, 4'd0);
      checkState("scan.l6a", 8'h40, 1'b1, 1'b0, 1'b0);
      tick(); checkState("scan.l6b", 8'h40, 1'b1, 1'b0, 1'b0);
      tick(); checkState("scan.l7a", 8'h80, 1'b1, 1'b0, 1'b0);
      tick(); checkState("scan.l7b", 8'h80, 1'b1, 1'b0, 1'b0);
      tick(); checkState("scan.l0a", 8'h01, 1'b1, 1'b1, 1'b0);
      tick(); checkState("scan.l0b", 8'h01, 1'b1, 1'b0, 1'b0);
      tick(); checkState("scan.l1a", 8'h02, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 4'd0);
      tick(); checkState("scan.exit", 8'h00, 1'b0, 1'b0, 1'b1);

      // SCAN dwell 0: one line per cycle, wrap every 8th
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b1, 4'd0);
      tick();
      checkState("walk.0", 8'h01, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b0, 4'd0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         checkOutput("walk.d", 32'(d), 32'(1) << (i % 8));
         checkOutput("walk.wrap", 32'(wrap), ((i % 8) == 0) ? 32'd1 : 32'd0);
      end

      // Abort with en_n
      applyStimulus(1'b1, 2'b10, 3'd0, 1'b0, 4'd0);
      checkOutput("en_abort.ready", 32'(addr_ready), 32'd0);
      tick();
      checkState("en_abort", 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 4'd0);
      tick();

      // Abort with mode change, then a fresh accept
      applyStimulus(1'b0, 2'b10, 3'd3, 1'b1, 4'd2);
      tick();
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b0, 4'd0);
      checkOutput("mode_abort.l3", 32'(d), 32'h08);
      tick();
      checkOutput("mode_abort.l3b", 32'(d), 32'h08);
      applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 4'd0);
      tick();
      checkState("mode_abort", 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 3'd2, 1'b1, 4'd0);
      tick();
      checkOutput("mode_abort.new", 32'(d), 32'h04);

      // Async reset between edges mid-scan
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b1, 4'd3);
      tick();
      applyStimulus(1'b0, 2'b10, 3'd0, 1'b0, 4'd3);
      tick();
      checkOutput("areset.pre", 32'(busy), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkState("areset", 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'd0, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("areset.wrap", 32'(wrap), 32'd0);
      end
      rst_n = 1'b1;
      #1;

      // First accept after reset, then mode 11 is refused and d holds
      applyStimulus(1'b0, 2'b00, 3'd7, 1'b1, 4'd0);
      tick();
      checkOutput("post_reset.a7", 32'(d), 32'h80);
      applyStimulus(1'b0, 2'b11, 3'd2, 1'b1, 4'd0);
      checkOutput("rsvd.ready", 32'(addr_ready), 32'd0);
      tick();
      checkOutput("rsvd.d1", 32'(d), 32'h80);
      tick();
      checkOutput("rsvd.d2", 32'(d), 32'h80);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // One-hot invariant on d, checked every cycle
   always @(negedge clk) begin
      if (rst_n && ($countones(d) > 1)) begin
         vectors++;
         errors++;
         $display("[TB] FAIL onehot: got %0h, expected at most one bit set", d);
      end
   end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 Parameter: N, default 3, address width; output width is 2**N.
REQ-002 Parameter: DWELL_W, default 4, width of the scan dwell count.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: en_n  input  1  active-low block enable; high forces outputs off.
REQ-006 Port: mode  input  2  00 STATIC, 01 PULSE, 10 SCAN, 11 reserved.
REQ-007 Port: addr  input  N  line index to decode, or the scan start index.
REQ-008 Port: addr_valid  input  1  addr/mode/dwell presented for acceptance.
REQ-009 Port: addr_ready  output  1  block can accept a request this cycle.
REQ-010 Port: dwell  input  DWELL_W  scan dwell; each line is active for dwell+1 cycles.
REQ-011 Port: d  output  2**N  registered one-hot (or all-zero) decoded lines.
REQ-012 Port: busy  output  1  high while in SCAN state.
REQ-013 Port: wrap  output  1  one-cycle pulse when a scan advances from line 2**N-1 to line 0.

Function
REQ-014 States SHALL be IDLE, HOLD and SCAN, with registered index (N bits) and dwell counter (DWELL_W bits).
REQ-015 addr_ready SHALL equal !en_n && state!=SCAN && mode!=11 (combinational).
REQ-016 Accept SHALL occur on a rising edge with addr_valid && addr_ready; mode, addr and dwell are sampled only at accept.
REQ-017 Latency: d SHALL reflect an accepted request on the cycle after accept; no combinational path from addr to d.
REQ-018 STATIC accept: d <= one-hot(addr), state -> HOLD; d held until the next accept, en_n high, or reset.
REQ-019 PULSE accept: d <= one-hot(addr) for exactly one cycle, then d <= 0, state -> IDLE.
REQ-020 SCAN accept: index <= addr, counter <= dwell, d <= one-hot(addr), busy <= 1, state -> SCAN.
REQ-021 In SCAN, counter SHALL decrement each cycle; at counter==0, index <= index+1 mod 2**N, counter <= sampled dwell, d <= one-hot(new index).
REQ-022 dwell==0 SHALL advance one line every cycle.
REQ-023 wrap SHALL be high for exactly the cycle d first shows line 0 after line 2**N-1; otherwise 0.
REQ-024 SCAN exit: mode input != 10 or en_n high SHALL on the next edge give d=0, busy=0, wrap=0, state IDLE.
REQ-025 In HOLD, an accept SHALL replace d directly with no all-zero gap cycle.
REQ-026 en_n high in any state SHALL on the next edge give d=0, state IDLE, counter=0; addr_ready stays 0 while en_n high.
REQ-027 mode 11 SHALL never be accepted; d keeps its current value.
REQ-028 d SHALL never have more than one bit set.

Reset
REQ-029 rst_n low SHALL immediately force d=0, busy=0, wrap=0, state IDLE, index=0, counter=0, independent of clk.
REQ-030 Reset mid-scan SHALL abort with no further wrap pulse; the first accept after release behaves as from power-up.
REQ-031 addr_ready SHALL be 0 while rst_n low.

Verification (N=3, DWELL_W=4)
REQ-032 STATIC: en_n=0, mode=00, addr=6 accepted -> next cycle d=8'b0100_0000, held 10 cycles; then addr=1 accepted -> d=8'b0000_0010 with no zero gap.
REQ-033 PULSE: mode=01, addr=5 accepted -> d=8'b0010_0000 for one cycle, then 8'h00; addr_ready=1 throughout.
REQ-034 SCAN wrap: mode=10, addr=6, dwell=1 -> d=line6 x2, line7 x2, line0 x2 with wrap=1 on the first line0 cycle only; busy=1 and addr_ready=0 throughout.
REQ-035 SCAN dwell=0 from addr=0 -> d walks lines 0..7 one per cycle; wrap=1 every 8th cycle.
REQ-036 Abort: mid-scan, drive en_n=1 -> next edge d=0, busy=0; separately, mode change to 00 mid-scan -> d=0 next edge, then a new accept is allowed.
REQ-037 Async reset: assert rst_n=0 between clock edges during SCAN -> d=0, busy=0 immediately; mode=11 with addr_valid=1 -> addr_ready=0 and d unchanged.
